// File: rtl/tcam_route_ctrl.sv
// Command initiator for the TCAM routing-table wrapper: arbitrates write, lookup
// and flush requests into one-cycle MODE pulses and returns lookup responses.
//
// state | meaning
// ------+------------------------------------------------------------------
// INIT  | first cycle after reset release, MODE=I
// IDLE  | arbitration point, priority fl_req > wr_valid > lk_valid
// FLUSH | MODE=F driven for one cycle, fl_done pulse
// WRITE | MODE=W driven for one cycle; also arbitrates so W->W / W->C run back to back
// CMP   | MODE=C driven for one cycle
// WAIT  | MODE=I, counting down to the cycle DstID_In is valid
// RSP   | response held until rsp_ready
module tcam_route_ctrl #(
    parameter int ID_Width    = 4,
    parameter int AddressSize = 4,
    parameter int LK_LAT      = 4,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [AddressSize-1:0]   wr_addr,
    input  logic [ID_Width-1:0]      wr_key,
    input  logic [ID_Width-1:0]      wr_dst,
    input  logic                     wr_en_entry,
    input  logic                     lk_valid,
    output logic                     lk_ready,
    input  logic [ID_Width-1:0]      lk_pkt_id,
    input  logic                     fl_req,
    output logic                     fl_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_Width-1:0]      rsp_dst,
    output logic                     rsp_hit,
    output logic [CNT_W-1:0]         lk_count,
    output logic [CNT_W-1:0]         hit_count,
    output logic [2:0]               MODE,
    output logic [ID_Width-1:0]      PacketID_In,
    output logic [2*ID_Width-1:0]    Data_In,
    output logic [2*ID_Width-1:0]    Mskb_In,
    output logic [AddressSize-1:0]   A_In,
    output logic                     Vbe_In,
    output logic                     Dcs_In,
    output logic                     Vbi_In,
    input  logic [ID_Width-1:0]      DstID_In
);

    localparam logic [2:0] MODE_I = 3'b000;
    localparam logic [2:0] MODE_W = 3'b001;
    localparam logic [2:0] MODE_F = 3'b011;
    localparam logic [2:0] MODE_C = 3'b100;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_FLUSH,
        S_WRITE,
        S_CMP,
        S_WAIT,
        S_RSP
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       arb_slot;
    logic       dst_hit;

    assign arb_slot = (state == S_IDLE) || (state == S_WRITE);
    assign wr_ready = arb_slot && !fl_req;
    assign lk_ready = arb_slot && !fl_req && !wr_valid;
    assign dst_hit  = (DstID_In != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_INIT;
            wait_cnt    <= '0;
            MODE        <= MODE_I;
            PacketID_In <= '0;
            Data_In     <= '0;
            Mskb_In     <= '0;
            A_In        <= '0;
            Vbe_In      <= 1'b0;
            Dcs_In      <= 1'b0;
            Vbi_In      <= 1'b0;
            fl_done     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_dst     <= '0;
            rsp_hit     <= 1'b0;
            lk_count    <= '0;
            hit_count   <= '0;
        end else begin
            // operands only live for the single command cycle
            MODE        <= MODE_I;
            PacketID_In <= '0;
            Data_In     <= '0;
            Mskb_In     <= '0;
            A_In        <= '0;
            Vbe_In      <= 1'b0;
            Dcs_In      <= 1'b0;
            Vbi_In      <= 1'b0;
            fl_done     <= 1'b0;

            case (state)
                S_INIT: state <= S_IDLE;
                S_IDLE, S_WRITE: begin
                    if (fl_req) begin
                        state   <= S_FLUSH;
                        MODE    <= MODE_F;
                        fl_done <= 1'b1;
                    end else if (wr_valid) begin
                        state   <= S_WRITE;
                        MODE    <= MODE_W;
                        Data_In <= {wr_key, wr_dst};
                        Mskb_In <= '1;
                        A_In    <= wr_addr;
                        Vbe_In  <= 1'b1;
                        Dcs_In  <= 1'b1;
                        Vbi_In  <= wr_en_entry;
                    end else if (lk_valid) begin
                        state       <= S_CMP;
                        MODE        <= MODE_C;
                        PacketID_In <= lk_pkt_id;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FLUSH: state <= S_IDLE;
                S_CMP: begin
                    state    <= S_WAIT;
                    wait_cnt <= 4'(LK_LAT - 1);
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= S_RSP;
                        rsp_valid <= 1'b1;
                        rsp_dst   <= DstID_In;
                        rsp_hit   <= dst_hit;
                        if (lk_count != '1)
                            lk_count <= lk_count + 1'b1;
                        if (dst_hit && (hit_count != '1))
                            hit_count <= hit_count + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_tcam_route_ctrl.sv
// Bench for tcam_route_ctrl: arbitration vector table, directed multi-cycle
// sequences, and randomized traffic against a route-table reference model.
module tb_tcam_route_ctrl;
    localparam int IDW = 4;
    localparam int AW  = 4;
    localparam int LAT = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            wr_valid, wr_ready, wr_en_entry;
    logic [AW-1:0]   wr_addr;
    logic [IDW-1:0]  wr_key, wr_dst;
    logic            lk_valid, lk_ready;
    logic [IDW-1:0]  lk_pkt_id;
    logic            fl_req, fl_done;
    logic            rsp_valid, rsp_ready, rsp_hit;
    logic [IDW-1:0]  rsp_dst;
    logic [CW-1:0]   lk_count, hit_count;
    logic [2:0]      MODE;
    logic [IDW-1:0]  PacketID_In;
    logic [2*IDW-1:0] Data_In, Mskb_In;
    logic [AW-1:0]   A_In;
    logic            Vbe_In, Dcs_In, Vbi_In;
    logic [IDW-1:0]  DstID_In;

    tcam_route_ctrl #(.ID_Width(IDW), .AddressSize(AW), .LK_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_key(wr_key),
        .wr_dst(wr_dst), .wr_en_entry(wr_en_entry),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_pkt_id(lk_pkt_id),
        .fl_req(fl_req), .fl_done(fl_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dst(rsp_dst), .rsp_hit(rsp_hit),
        .lk_count(lk_count), .hit_count(hit_count),
        .MODE(MODE), .PacketID_In(PacketID_In), .Data_In(Data_In), .Mskb_In(Mskb_In),
        .A_In(A_In), .Vbe_In(Vbe_In), .Dcs_In(Dcs_In), .Vbi_In(Vbi_In),
        .DstID_In(DstID_In)
    );

    // Wrapper model: a TCAM table driven only by the MODE bus, returning the
    // lowest-address matching entry LAT cycles after the compare cycle.
    logic           tc_v[16];
    logic [IDW-1:0] tc_k[16];
    logic [IDW-1:0] tc_d[16];
    int             ncyc = 0;
    int             pend_at = -1;
    logic [IDW-1:0] pend_res = '0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            tc_v[i] = 1'b0; tc_k[i] = '0; tc_d[i] = '0;
        end
        DstID_In = '0;
    end

    always @(negedge clk) begin
        ncyc++;
        if (MODE == 3'b001) begin
            tc_v[A_In] = Vbi_In;
            tc_k[A_In] = Data_In[2*IDW-1:IDW];
            tc_d[A_In] = Data_In[IDW-1:0];
        end else if (MODE == 3'b011) begin
            for (int i = 0; i < 16; i++) tc_v[i] = 1'b0;
        end else if (MODE == 3'b100) begin
            pend_res = '0;
            for (int i = 15; i >= 0; i--)
                if (tc_v[i] && tc_k[i] == PacketID_In) pend_res = tc_d[i];
            pend_at = ncyc + LAT;
        end
        DstID_In = (ncyc == pend_at) ? pend_res : ~pend_res;
    end

    // Reference route table, updated on accepted handshakes.
    logic           rf_v[16];
    logic [IDW-1:0] rf_k[16];
    logic [IDW-1:0] rf_d[16];

    function automatic logic [IDW-1:0] ref_find(input logic [IDW-1:0] key);
        logic [IDW-1:0] r = '0;
        for (int i = 15; i >= 0; i--)
            if (rf_v[i] && rf_k[i] == key) r = rf_d[i];
        return r;
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        wr_valid = 0; wr_addr = '0; wr_key = '0; wr_dst = '0; wr_en_entry = 0;
        lk_valid = 0; lk_pkt_id = '0; fl_req = 0; rsp_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; tick(); tick();
        rst_n = 1; tick();
    endtask

    // Issue one lookup from IDLE, return latency (ticks from acceptance to rsp_valid).
    task automatic lookup(input logic [IDW-1:0] key, output logic [IDW-1:0] dst,
                          output logic hit, output int lat, output int ncmp);
        lk_valid = 1; lk_pkt_id = key;
        tick();
        lk_valid = 0;
        lat = 1; ncmp = (MODE == 3'b100) ? 1 : 0;
        while (!rsp_valid && lat < 30) begin
            tick(); lat++;
            if (MODE == 3'b100) ncmp++;
        end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
        dst = rsp_dst; hit = rsp_hit;
    endtask

    task automatic consume();
        rsp_ready = 1; tick(); rsp_ready = 0;
    endtask

    typedef struct {
        logic fl, wr, lk;
        logic exp_wrr, exp_lkr;
        logic [2:0] exp_mode;
    } arb_vec_t;

    arb_vec_t av[8];
    logic [IDW-1:0] d;
    logic h;
    int lat, ncmp, bad, cnt;
    logic [IDW-1:0] exp_q[$];
    int nlk, nhit;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        av[0] = '{0,0,0, 1,1, 3'b000};
        av[1] = '{0,0,1, 1,1, 3'b100};
        av[2] = '{0,1,0, 1,0, 3'b001};
        av[3] = '{0,1,1, 1,0, 3'b001};
        av[4] = '{1,0,0, 0,0, 3'b011};
        av[5] = '{1,0,1, 0,0, 3'b011};
        av[6] = '{1,1,0, 0,0, 3'b011};
        av[7] = '{1,1,1, 0,0, 3'b011};

        clear_inputs();
        rst_n = 0;
        tick(); tick(); tick();
        chk("rst_mode", MODE, 0);
        chk("rst_readies", {wr_ready, lk_ready}, 0);
        chk("rst_rsp", {rsp_valid, rsp_hit, rsp_dst}, 0);
        chk("rst_fl_done", fl_done, 0);
        chk("rst_counts", {lk_count, hit_count}, 0);
        chk("rst_operands", {PacketID_In, Data_In, Mskb_In, A_In, Vbe_In, Dcs_In, Vbi_In}, 0);
        rst_n = 1; #1;
        chk("init_wr_ready", wr_ready, 0);
        tick();
        chk("idle_wr_ready", wr_ready, 1);
        chk("idle_mode", MODE, 0);

        // arbitration table
        for (int i = 0; i < 8; i++) begin
            fl_req = av[i].fl; wr_valid = av[i].wr; lk_valid = av[i].lk;
            wr_addr = 4'hF; wr_key = 4'hF; wr_dst = 4'h0; wr_en_entry = 0; lk_pkt_id = 4'hE;
            #1;
            chk($sformatf("arb%0d_wr_ready", i), wr_ready, av[i].exp_wrr);
            chk($sformatf("arb%0d_lk_ready", i), lk_ready, av[i].exp_lkr);
            tick();
            clear_inputs();
            chk($sformatf("arb%0d_mode", i), MODE, av[i].exp_mode);
            chk($sformatf("arb%0d_fl_done", i), fl_done, av[i].exp_mode == 3'b011);
            rsp_ready = 1;
            repeat (LAT + 4) tick();
            rsp_ready = 0;
        end
        chk("arb_lk_count", lk_count, 1);
        chk("arb_hit_count", hit_count, 0);

        // write sequence
        do_reset();
        wr_valid = 1; wr_addr = 3; wr_key = 4'hA; wr_dst = 4'h5; wr_en_entry = 1;
        tick();
        wr_valid = 0;
        chk("wr_mode", MODE, 3'b001);
        chk("wr_data", Data_In, 8'hA5);
        chk("wr_mask", Mskb_In, 8'hFF);
        chk("wr_addr", A_In, 3);
        chk("wr_bits", {Vbe_In, Dcs_In, Vbi_In}, 3'b111);
        chk("wr_pkt", PacketID_In, 0);
        tick();
        chk("wr_after_mode", MODE, 0);
        chk("wr_after_ops", {Data_In, A_In, Vbi_In}, 0);

        // back-to-back writes
        wr_valid = 1; wr_addr = 6; wr_key = 4'h7; wr_dst = 4'h9; wr_en_entry = 1;
        tick();
        chk("b2b_first_addr", A_In, 6);
        wr_addr = 7; wr_key = 4'h8; wr_dst = 4'hC; wr_en_entry = 0;
        tick();
        wr_valid = 0;
        chk("b2b_second", {MODE, A_In, Vbi_In, Data_In}, {3'b001, 4'd7, 1'b0, 8'h8C});
        tick();
        chk("b2b_end_mode", MODE, 0);

        // lookup hit
        lookup(4'hA, d, h, lat, ncmp);
        chk("lk_latency", lat, LAT + 2);
        chk("lk_cmp_cycles", ncmp, 1);
        chk("lk_dst", d, 5);
        chk("lk_hit", h, 1);
        consume();
        chk("lk_rsp_drop", rsp_valid, 0);
        chk("lk_counts", {lk_count, hit_count}, {4'd1, 4'd1});

        // lookup miss
        lookup(4'h3, d, h, lat, ncmp);
        chk("miss_dst", d, 0);
        chk("miss_hit", h, 0);
        consume();
        chk("miss_counts", {lk_count, hit_count}, {4'd2, 4'd1});

        // response back-pressure with a pending write
        lookup(4'hA, d, h, lat, ncmp);
        wr_valid = 1; wr_addr = 4; wr_key = 4'h1; wr_dst = 4'h2; wr_en_entry = 1;
        bad = 0;
        repeat (10) begin
            #1;
            if (!rsp_valid || rsp_dst != 5 || !rsp_hit || wr_ready || MODE != 0) bad++;
            tick();
        end
        chk("hold_stable", bad, 0);
        rsp_ready = 1; tick(); rsp_ready = 0;
        #1;
        chk("hold_release", {rsp_valid, wr_ready}, 2'b01);
        tick();
        wr_valid = 0;
        chk("hold_write", {MODE, A_In}, {3'b001, 4'd4});
        tick();

        // flush beats lookup
        fl_req = 1; lk_valid = 1; lk_pkt_id = 4'hA;
        #1;
        chk("fl_lk_ready", lk_ready, 0);
        tick();
        fl_req = 0;
        chk("fl_mode", {MODE, fl_done}, {3'b011, 1'b1});
        tick();
        #1;
        chk("fl_idle", {MODE, fl_done, lk_ready}, {3'b000, 1'b0, 1'b1});
        tick();
        lk_valid = 0;
        chk("fl_then_cmp", MODE, 3'b100);
        cnt = 0;
        while (!rsp_valid && cnt < 30) begin tick(); cnt++; end
        chk("fl_lk_dst", {rsp_valid, rsp_dst}, {1'b1, 4'h0});
        consume();
        chk("fl_counts", {lk_count, hit_count}, {4'd4, 4'd2});

        // level flush request: one flush per IDLE visit
        fl_req = 1; cnt = 0;
        repeat (4) begin tick(); cnt += fl_done; end
        fl_req = 0;
        chk("fl_level_count", cnt, 2);
        tick();

        // reset during WAIT
        lk_valid = 1; lk_pkt_id = 4'h1;
        tick();
        lk_valid = 0;
        tick(); tick();
        rst_n = 0; tick(); rst_n = 1;
        bad = 0;
        repeat (15) begin tick(); if (rsp_valid) bad++; end
        chk("rst_wait_no_rsp", bad, 0);
        chk("rst_wait_counts", {lk_count, hit_count}, 0);

        // randomized traffic against the reference table
        fl_req = 1; tick(); fl_req = 0; tick(); tick();
        for (int i = 0; i < 16; i++) begin
            rf_v[i] = 1'b0; rf_k[i] = '0; rf_d[i] = '0;
        end
        nlk = 0; nhit = 0;
        for (int it = 0; it < 520; it++) begin
            if (it < 500) begin
                wr_valid    = ($urandom_range(0, 3) == 0);
                wr_addr     = 4'($urandom_range(0, 15));
                wr_key      = 4'($urandom_range(0, 3));
                wr_dst      = 4'($urandom_range(0, 15));
                wr_en_entry = ($urandom_range(0, 3) != 0);
                lk_valid    = ($urandom_range(0, 1) == 0);
                lk_pkt_id   = 4'($urandom_range(0, 3));
                rsp_ready   = ($urandom_range(0, 9) < 7);
            end else begin
                clear_inputs();
                rsp_ready = 1;
            end
            #1;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_rsp_unexpected", 1, 0);
                end else begin
                    chk("rnd_rsp_dst", rsp_dst, exp_q[0]);
                    chk("rnd_rsp_hit", rsp_hit, exp_q[0] != 0);
                    void'(exp_q.pop_front());
                end
            end
            if (wr_valid && wr_ready) begin
                rf_v[wr_addr] = wr_en_entry;
                rf_k[wr_addr] = wr_key;
                rf_d[wr_addr] = wr_dst;
            end
            if (lk_valid && lk_ready) begin
                exp_q.push_back(ref_find(lk_pkt_id));
                nlk++;
                if (ref_find(lk_pkt_id) != 0) nhit++;
            end
            tick();
        end
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_lk_count", lk_count, (nlk > CMAX) ? CMAX : nlk);
        chk("rnd_hit_count", hit_count, (nhit > CMAX) ? CMAX : nhit);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
